// File: rtl/switch_alloc_rr.sv
// Separable switch allocator for a 5-port mesh router: per-input output pick,
// then per-output round-robin arbitration with wormhole locking from head to tail.
module switch_alloc_rr #(
    parameter int NUM_PORT = 5,
    parameter int SEL_W    = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORT-1:0]            req_valid,
    input  logic [NUM_PORT*NUM_PORT-1:0]   prod_vec,
    input  logic [NUM_PORT-1:0]            flit_head,
    input  logic [NUM_PORT-1:0]            flit_tail,
    input  logic [NUM_PORT-1:0]            out_ready,
    output logic [NUM_PORT-1:0]            in_grant,
    output logic [NUM_PORT-1:0]            out_valid,
    output logic [NUM_PORT*SEL_W-1:0]      out_sel,
    output logic [NUM_PORT-1:0]            out_locked
);

    logic [SEL_W-1:0] ptr_q   [NUM_PORT];
    logic [SEL_W-1:0] ptr_d   [NUM_PORT];
    logic [SEL_W-1:0] owner_q [NUM_PORT];
    logic [SEL_W-1:0] owner_d [NUM_PORT];
    logic [NUM_PORT-1:0] lock_q;
    logic [NUM_PORT-1:0] lock_d;

    // req_in[i] is the one-hot output requested by input i
    logic [NUM_PORT-1:0][NUM_PORT-1:0] req_in;
    // grant_out[o] is the one-hot winning input at output o
    logic [NUM_PORT-1:0][NUM_PORT-1:0] grant_out;

    // Dimension-ordered preference: X (E then W), then Y (N then S), then Local and beyond.
    function automatic logic [NUM_PORT-1:0] pick_head(input logic [NUM_PORT-1:0] pv);
        logic [NUM_PORT-1:0] r;
        r = '0;
        if (pv[1]) begin
            r[1] = 1'b1;
        end else if (pv[0]) begin
            r[0] = 1'b1;
        end else if (pv[3]) begin
            r[3] = 1'b1;
        end else if (pv[2]) begin
            r[2] = 1'b1;
        end else begin
            for (int b = NUM_PORT - 1; b >= 4; b--) begin
                if (pv[b]) begin
                    r    = '0;
                    r[b] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        logic found;
        req_in = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_PORT; i++) begin
            if (req_valid[i]) begin
                if (flit_head[i]) begin
                    req_in[i] = pick_head(prod_vec[i*NUM_PORT +: NUM_PORT]);
                end else begin
                    // Body/tail flits follow the lock they own, regardless of routing.
                    found = 1'b0;
                    for (int o = 0; o < NUM_PORT; o++) begin
                        if (!found && lock_q[o] && owner_q[o] == SEL_W'(i)) begin
                            req_in[i][o] = 1'b1;
                            found        = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        logic found;
        int   idx;
        grant_out = '0;
        found     = 1'b0;
        idx       = 0;
        for (int o = 0; o < NUM_PORT; o++) begin
            found = 1'b0;
            if (!reset && out_ready[o]) begin
                if (lock_q[o]) begin
                    for (int i = 0; i < NUM_PORT; i++) begin
                        if (owner_q[o] == SEL_W'(i) && req_in[i][o] && !flit_head[i]) begin
                            grant_out[o][i] = 1'b1;
                        end
                    end
                end else begin
                    for (int k = 0; k < NUM_PORT; k++) begin
                        idx = (int'(ptr_q[o]) + k) % NUM_PORT;
                        if (!found && req_in[idx][o] && flit_head[idx]) begin
                            grant_out[o][idx] = 1'b1;
                            found             = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        in_grant  = '0;
        out_valid = '0;
        out_sel   = '0;
        for (int o = 0; o < NUM_PORT; o++) begin
            out_valid[o] = |grant_out[o];
            for (int i = 0; i < NUM_PORT; i++) begin
                if (grant_out[o][i]) begin
                    in_grant[i]                = 1'b1;
                    out_sel[o*SEL_W +: SEL_W]  = SEL_W'(i);
                end
            end
        end
    end

    // Heads advance the pointer past the winner; only a multi-flit head takes the lock.
    always_comb begin
        lock_d = lock_q;
        for (int o = 0; o < NUM_PORT; o++) begin
            ptr_d[o]   = ptr_q[o];
            owner_d[o] = owner_q[o];
            for (int i = 0; i < NUM_PORT; i++) begin
                if (grant_out[o][i]) begin
                    if (flit_head[i]) begin
                        ptr_d[o] = SEL_W'((i + 1) % NUM_PORT);
                        if (!flit_tail[i]) begin
                            lock_d[o]  = 1'b1;
                            owner_d[o] = SEL_W'(i);
                        end
                    end else if (flit_tail[i]) begin
                        lock_d[o] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q <= '0;
            for (int o = 0; o < NUM_PORT; o++) begin
                ptr_q[o]   <= '0;
                owner_q[o] <= '0;
            end
        end else begin
            lock_q <= lock_d;
            for (int o = 0; o < NUM_PORT; o++) begin
                ptr_q[o]   <= ptr_d[o];
                owner_q[o] <= owner_d[o];
            end
        end
    end

    assign out_locked = lock_q;

endmodule

// File: tb/tb_switch_alloc_rr.sv
// Directed bench for switch_alloc_rr: a cycle-by-cycle vector table followed by
// hand-written sequences for stalled wormhole packets and reset mid-packet.
module tb_switch_alloc_rr;

    localparam logic [4:0] PW = 5'b00001;
    localparam logic [4:0] PE = 5'b00010;
    localparam logic [4:0] PS = 5'b00100;
    localparam logic [4:0] PN = 5'b01000;
    localparam logic [4:0] PL = 5'b10000;

    typedef struct {
        logic        rst;
        logic [4:0]  rv;
        logic [24:0] pv;
        logic [4:0]  hd;
        logic [4:0]  tl;
        logic [4:0]  rdy;
        logic [4:0]  e_gnt;
        logic [4:0]  e_val;
        logic [14:0] e_sel;
        logic [4:0]  e_lck;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [4:0]  req_valid;
    logic [24:0] prod_vec;
    logic [4:0]  flit_head;
    logic [4:0]  flit_tail;
    logic [4:0]  out_ready;
    logic [4:0]  in_grant;
    logic [4:0]  out_valid;
    logic [14:0] out_sel;
    logic [4:0]  out_locked;

    int   n_cmp;
    int   n_bad;
    int   vec_id;
    vec_t tbl[$];

    switch_alloc_rr dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .prod_vec   (prod_vec),
        .flit_head  (flit_head),
        .flit_tail  (flit_tail),
        .out_ready  (out_ready),
        .in_grant   (in_grant),
        .out_valid  (out_valid),
        .out_sel    (out_sel),
        .out_locked (out_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [24:0] pvOne(input int i, input logic [4:0] v);
        logic [24:0] r;
        r = '0;
        r[i*5 +: 5] = v;
        return r;
    endfunction

    function automatic logic [14:0] sel(input int o, input int i);
        logic [14:0] r;
        logic [2:0]  iv;
        r  = '0;
        iv = 3'(i);
        r[o*3 +: 3] = iv;
        return r;
    endfunction

    function automatic vec_t mk(input logic rst, input logic [4:0] rv, input logic [24:0] pv,
                                input logic [4:0] hd, input logic [4:0] tl, input logic [4:0] rdy,
                                input logic [4:0] e_gnt, input logic [4:0] e_val,
                                input logic [14:0] e_sel, input logic [4:0] e_lck);
        vec_t v;
        v.rst = rst; v.rv = rv; v.pv = pv; v.hd = hd; v.tl = tl; v.rdy = rdy;
        v.e_gnt = e_gnt; v.e_val = e_val; v.e_sel = e_sel; v.e_lck = e_lck;
        return v;
    endfunction

    // Drive one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        reset     = v.rst;
        req_valid = v.rv;
        prod_vec  = v.pv;
        flit_head = v.hd;
        flit_tail = v.tl;
        out_ready = v.rdy;
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s vec %0d: got %0h, expected %0h", name, vec_id, act, exp);
        end
    endtask

    // Sample on the falling edge, well away from the state update.
    task automatic checkOutput(input vec_t v);
        @(negedge clk);
        checkField("in_grant",   32'(in_grant),   32'(v.e_gnt));
        checkField("out_valid",  32'(out_valid),  32'(v.e_val));
        checkField("out_sel",    32'(out_sel),    32'(v.e_sel));
        checkField("out_locked", 32'(out_locked), 32'(v.e_lck));
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        checkOutput(v);
        vec_id++;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; vec_id = 0;
        reset = 1'b1; req_valid = '0; prod_vec = '0;
        flit_head = '0; flit_tail = '0; out_ready = '1;
        @(posedge clk);
        @(posedge clk);

        // Reset held with every input requesting: nothing may be granted.
        tbl.push_back(mk(1, 5'b11111, pvOne(0,PE)|pvOne(1,PE)|pvOne(2,PE)|pvOne(3,PE)|pvOne(4,PE),
                         5'b11111, 5'b11111, 5'b11111, 5'b00000, 5'b00000, sel(0,0), 5'b00000));
        // Single-flit heads from in0, in2, in3 to E rotate through ptr[1].
        tbl.push_back(mk(0, 5'b01101, pvOne(0,PE)|pvOne(2,PE)|pvOne(3,PE),
                         5'b01101, 5'b01101, 5'b11111, 5'b00001, PE, sel(1,0), 5'b00000));
        tbl.push_back(mk(0, 5'b01100, pvOne(2,PE)|pvOne(3,PE),
                         5'b01100, 5'b01100, 5'b11111, 5'b00100, PE, sel(1,2), 5'b00000));
        tbl.push_back(mk(0, 5'b01000, pvOne(3,PE),
                         5'b01000, 5'b01000, 5'b11111, 5'b01000, PE, sel(1,3), 5'b00000));
        // ptr[1] is now 4: in4 beats in0, then in0 alone.
        tbl.push_back(mk(0, 5'b10001, pvOne(0,PE)|pvOne(4,PE),
                         5'b10001, 5'b10001, 5'b11111, 5'b10000, PE, sel(1,4), 5'b00000));
        tbl.push_back(mk(0, 5'b00001, pvOne(0,PE),
                         5'b00001, 5'b00001, 5'b11111, 5'b00001, PE, sel(1,0), 5'b00000));
        // Move ptr[3] to 4, then in4 3-flit packet to N against an in1 head.
        tbl.push_back(mk(0, 5'b01000, pvOne(3,PN),
                         5'b01000, 5'b01000, 5'b11111, 5'b01000, PN, sel(3,3), 5'b00000));
        tbl.push_back(mk(0, 5'b10010, pvOne(1,PN)|pvOne(4,PN),
                         5'b10010, 5'b00010, 5'b11111, 5'b10000, PN, sel(3,4), 5'b00000));
        tbl.push_back(mk(0, 5'b10010, pvOne(1,PN),
                         5'b00010, 5'b00010, 5'b11111, 5'b10000, PN, sel(3,4), 5'b01000));
        tbl.push_back(mk(0, 5'b10010, pvOne(1,PN),
                         5'b00010, 5'b10010, 5'b11111, 5'b10000, PN, sel(3,4), 5'b01000));
        tbl.push_back(mk(0, 5'b00010, pvOne(1,PN),
                         5'b00010, 5'b00010, 5'b11111, 5'b00010, PN, sel(3,1), 5'b00000));
        // E preferred over N.
        tbl.push_back(mk(0, 5'b00001, pvOne(0,5'b01010),
                         5'b00001, 5'b00001, 5'b11111, 5'b00001, PE, sel(1,0), 5'b00000));
        // Head with empty productive vector, and body with no lock: both ignored.
        tbl.push_back(mk(0, 5'b00101, pvOne(2,PE),
                         5'b00001, 5'b00101, 5'b11111, 5'b00000, 5'b00000, sel(0,0), 5'b00000));
        // No credit on an unlocked output.
        tbl.push_back(mk(0, 5'b00001, pvOne(0,PW),
                         5'b00001, 5'b00001, 5'b11110, 5'b00000, 5'b00000, sel(0,0), 5'b00000));
        // Move ptr[4] to 2, then in1/in2 contend for Local.
        tbl.push_back(mk(0, 5'b00010, pvOne(1,PL),
                         5'b00010, 5'b00010, 5'b11111, 5'b00010, PL, sel(4,1), 5'b00000));
        tbl.push_back(mk(0, 5'b00110, pvOne(1,PL)|pvOne(2,PL),
                         5'b00110, 5'b00110, 5'b11111, 5'b00100, PL, sel(4,2), 5'b00000));
        tbl.push_back(mk(0, 5'b00010, pvOne(1,PL),
                         5'b00010, 5'b00010, 5'b11111, 5'b00010, PL, sel(4,1), 5'b00000));

        for (int k = 0; k < tbl.size(); k++) begin
            runVec(tbl[k]);
        end

        // Locked packet on S stalls on credit while a competing head waits.
        runVec(mk(0, 5'b01001, pvOne(0,PS)|pvOne(3,PS), 5'b01001, 5'b01000, 5'b11111,
                  5'b00001, PS, sel(2,0), 5'b00000));
        for (int k = 0; k < 3; k++) begin
            runVec(mk(0, 5'b01001, pvOne(0,PS)|pvOne(3,PS), 5'b01000, 5'b01000, 5'b11011,
                      5'b00000, 5'b00000, sel(0,0), PS));
        end
        runVec(mk(0, 5'b01001, pvOne(0,PS)|pvOne(3,PS), 5'b01000, 5'b01000, 5'b11111,
                  5'b00001, PS, sel(2,0), PS));
        runVec(mk(0, 5'b01001, pvOne(0,PS)|pvOne(3,PS), 5'b01000, 5'b01001, 5'b11111,
                  5'b00001, PS, sel(2,0), PS));
        runVec(mk(0, 5'b01000, pvOne(3,PS), 5'b01000, 5'b01000, 5'b11111,
                  5'b01000, PS, sel(2,3), 5'b00000));

        // Reset in the middle of an in1 packet on W drops the lock.
        runVec(mk(0, 5'b00010, pvOne(1,PW), 5'b00010, 5'b00000, 5'b11111,
                  5'b00010, PW, sel(0,1), 5'b00000));
        runVec(mk(0, 5'b00010, pvOne(1,PW), 5'b00000, 5'b00000, 5'b11111,
                  5'b00010, PW, sel(0,1), PW));
        runVec(mk(1, 5'b00010, pvOne(1,PW), 5'b00000, 5'b00000, 5'b11111,
                  5'b00000, 5'b00000, sel(0,0), PW));
        runVec(mk(0, 5'b00010, pvOne(1,PW), 5'b00000, 5'b00000, 5'b11111,
                  5'b00000, 5'b00000, sel(0,0), 5'b00000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
